// File: rtl/forth_pkg.sv
// Shared opcode and stack-slave op types for the Forth data-stack sequencer.
package forth_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_PUSH = 4'd1,
        OP_DUP  = 4'd2,
        OP_OVER = 4'd3,
        OP_DROP = 4'd4,
        OP_SWAP = 4'd5,
        OP_ROT  = 4'd6,
        OP_ADD  = 4'd7,
        OP_SUB  = 4'd8,
        OP_AND  = 4'd9,
        OP_OR   = 4'd10,
        OP_XOR  = 4'd11
    } sq_op_t;

    typedef enum logic [1:0] {
        SS_NOP  = 2'd0,
        SS_PUSH = 2'd1,
        SS_POP  = 2'd2
    } ss_op_t;

    localparam logic [3:0] SQ_OP_MAX = 4'd11;

    // Cells (including the cached TOS) an opcode consumes before it may run.
    function automatic logic [1:0] sq_min_depth(input sq_op_t op);
        case (op)
            OP_DUP, OP_DROP:                                       return 2'd1;
            OP_OVER, OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 2'd2;
            OP_ROT:                                                return 2'd3;
            default:                                               return 2'd0;
        endcase
    endfunction

    function automatic logic sq_grows(input sq_op_t op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/ss_io.sv
// Sequencer-to-stack-slave link: one push/pop request per cycle, s is the slave's top entry.
interface ss_io #(
    parameter int DSZ = 32
) ();
    forth_pkg::ss_op_t  op;
    logic [DSZ-1:0]     vi;
    logic [DSZ-1:0]     s;

    modport master (output op, output vi, input s);
    modport slave  (input op, input vi, output s);
endinterface

// File: rtl/dstack_alu.sv
// Combinational two-operand ALU, y = a op b (a is NOS, b is TOS); zero latency, no flow control.
module dstack_alu
    import forth_pkg::*;
#(
    parameter int DSZ = 32
) (
    input  sq_op_t         op,
    input  logic [DSZ-1:0] a,
    input  logic [DSZ-1:0] b,
    output logic [DSZ-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/dstack_ss.sv
// Stack slave: DEPTH-entry LIFO behind ss_io; push/pop commit at the next edge, s reads 0 when empty.
// Pushes while full and pops while empty are dropped.
module dstack_ss
    import forth_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DSZ   = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    ss_io.slave  ss_if
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DSZ-1:0] r_mem [DEPTH];
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_top;
    logic           w_push;
    logic           w_pop;

    assign w_top   = r_cnt - CW'(1);
    assign w_push  = (ss_if.op == SS_PUSH) && (r_cnt != CW'(DEPTH));
    assign w_pop   = (ss_if.op == SS_POP) && (r_cnt != '0);
    assign ss_if.s = (r_cnt == '0) ? '0 : r_mem[w_top[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_push) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (w_pop) begin
            r_cnt <= w_top;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_cnt[AW-1:0]] <= ss_if.vi;
        end
    end

endmodule

// File: rtl/dstack_seq.sv
// Forth data-stack sequencer with cached TOS over an ss_io slave; ROT, S2/S3 and tmp2 exist only with DSTACK_SEQ_ROT_EN.
// Most ops take 1 cycle, SWAP 2, ROT 4; cmd_ready is low while busy, in reset or with en low (en low freezes everything).
module dstack_seq
    import forth_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DSZ   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [DSZ-1:0]           cmd_val,
    output logic [DSZ-1:0]           tos,
    output logic [$clog2(DEPTH+1):0] depth,
    output logic                     busy,
    output logic                     err,
    ss_io.master                     ss_if
);

    localparam int DW = $clog2(DEPTH + 1) + 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH + 1);

`ifdef DSTACK_SEQ_ROT_EN
    typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;
    localparam bit ROT_EN = 1'b1;
`else
    typedef enum logic [1:0] {IDLE, S1} state_t;
    localparam bit ROT_EN = 1'b0;
`endif

    state_t         r_state, w_state_nxt;
    logic [DSZ-1:0] r_tos, w_tos_nxt;
    logic [DW-1:0]  r_depth, w_depth_nxt;
    logic           r_err, w_err_nxt;
    logic [DSZ-1:0] r_tmp, w_tmp_nxt;
`ifdef DSTACK_SEQ_ROT_EN
    logic [DSZ-1:0] r_tmp2, w_tmp2_nxt;
    logic           r_rot, w_rot_nxt;
`endif

    sq_op_t         w_op;
    logic [DW-1:0]  w_need;
    logic           w_fault;
    logic [DSZ-1:0] w_alu_y;
    ss_op_t         w_ss_op;
    logic [DSZ-1:0] w_ss_vi;

    assign w_op    = sq_op_t'(cmd_op);
    assign w_need  = DW'(sq_min_depth(w_op));
    assign w_fault = (cmd_op > SQ_OP_MAX) || ((w_op == OP_ROT) && !ROT_EN) ||
                     (r_depth < w_need) || (sq_grows(w_op) && (r_depth == FULL));

    dstack_alu #(.DSZ(DSZ)) u_alu (
        .op (w_op),
        .a  (ss_if.s),
        .b  (r_tos),
        .y  (w_alu_y)
    );

    assign cmd_ready   = !rst && en && (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign tos         = r_tos;
    assign depth       = r_depth;
    assign err         = r_err;
    assign ss_if.op    = w_ss_op;
    assign ss_if.vi    = w_ss_vi;

    always_comb begin
        w_state_nxt = r_state;
        w_tos_nxt   = r_tos;
        w_depth_nxt = r_depth;
        w_err_nxt   = r_err;
        w_tmp_nxt   = r_tmp;
`ifdef DSTACK_SEQ_ROT_EN
        w_tmp2_nxt  = r_tmp2;
        w_rot_nxt   = r_rot;
`endif
        w_ss_op     = SS_NOP;
        w_ss_vi     = r_tos;
        if (!rst && en) begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (w_fault) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            case (w_op)
                                OP_PUSH: begin
                                    // At depth 0 the cached TOS is not a live cell, so it is not spilled.
                                    if (r_depth != '0) w_ss_op = SS_PUSH;
                                    w_tos_nxt   = cmd_val;
                                    w_depth_nxt = r_depth + DW'(1);
                                end
                                OP_DUP: begin
                                    w_ss_op     = SS_PUSH;
                                    w_depth_nxt = r_depth + DW'(1);
                                end
                                OP_OVER: begin
                                    w_ss_op     = SS_PUSH;
                                    w_tos_nxt   = ss_if.s;
                                    w_depth_nxt = r_depth + DW'(1);
                                end
                                OP_DROP: begin
                                    if (r_depth > DW'(1)) w_ss_op = SS_POP;
                                    w_tos_nxt   = ss_if.s;
                                    w_depth_nxt = r_depth - DW'(1);
                                end
                                OP_SWAP: begin
                                    w_ss_op     = SS_POP;
                                    w_tmp_nxt   = r_tos;
                                    w_tos_nxt   = ss_if.s;
                                    w_state_nxt = S1;
`ifdef DSTACK_SEQ_ROT_EN
                                    w_rot_nxt   = 1'b0;
`endif
                                end
`ifdef DSTACK_SEQ_ROT_EN
                                OP_ROT: begin
                                    w_ss_op     = SS_POP;
                                    w_tmp_nxt   = ss_if.s;
                                    w_state_nxt = S1;
                                    w_rot_nxt   = 1'b1;
                                end
`endif
                                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                    w_ss_op     = SS_POP;
                                    w_tos_nxt   = w_alu_y;
                                    w_depth_nxt = r_depth - DW'(1);
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S1: begin
`ifdef DSTACK_SEQ_ROT_EN
                    if (r_rot) begin
                        w_ss_op     = SS_POP;
                        w_tos_nxt   = ss_if.s;
                        w_tmp2_nxt  = r_tos;
                        w_state_nxt = S2;
                    end else
`endif
                    begin
                        w_ss_op     = SS_PUSH;
                        w_ss_vi     = r_tmp;
                        w_state_nxt = IDLE;
                    end
                end
`ifdef DSTACK_SEQ_ROT_EN
                S2: begin
                    w_ss_op     = SS_PUSH;
                    w_ss_vi     = r_tmp;
                    w_state_nxt = S3;
                end
                S3: begin
                    w_ss_op     = SS_PUSH;
                    w_ss_vi     = r_tmp2;
                    w_state_nxt = IDLE;
                end
`endif
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tos   <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
            r_tmp   <= '0;
`ifdef DSTACK_SEQ_ROT_EN
            r_tmp2  <= '0;
            r_rot   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_tos   <= w_tos_nxt;
            r_depth <= w_depth_nxt;
            r_err   <= w_err_nxt;
            r_tmp   <= w_tmp_nxt;
`ifdef DSTACK_SEQ_ROT_EN
            r_tmp2  <= w_tmp2_nxt;
            r_rot   <= w_rot_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_dstack_seq.sv
// Bench for dstack_seq: directed scenarios then random ops against a queue-based stack model.
module tb_dstack_seq;
    import forth_pkg::*;

    localparam int DEPTH = 16;
    localparam int DSZ   = 32;
`ifdef DSTACK_SEQ_ROT_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, en, cmd_valid, cmd_ready, busy, err;
    logic [3:0]     cmd_op;
    logic [DSZ-1:0] cmd_val, tos;
    logic [5:0]     depth;

    ss_io #(.DSZ(DSZ)) ss ();

    dstack_seq #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_val   (cmd_val),
        .tos       (tos),
        .depth     (depth),
        .busy      (busy),
        .err       (err),
        .ss_if     (ss)
    );

    dstack_ss #(.DEPTH(DEPTH), .DSZ(DSZ)) u_ss (
        .i_clk (clk),
        .i_rst (rst),
        .ss_if (ss)
    );

    always #5 clk = ~clk;

    int             checks   = 0;
    int             failures = 0;
    logic [31:0]    m[$];
    logic           m_err;
    logic [3:0]     rop;
    int             rsel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_tos();
        return (m.size() > 0) ? m[m.size()-1] : 32'd0;
    endfunction

    function automatic logic [31:0] m_nos();
        return (m.size() > 1) ? m[m.size()-2] : 32'd0;
    endfunction

    // Applies one command to the model; returns the cycles the command should occupy.
    function automatic int model_step(input logic [3:0] op, input logic [31:0] v);
        int          need;
        bit          grows;
        bit          legal;
        logic [31:0] a, b, c;
        legal = (op <= 4'd11) && !((op == OP_ROT) && !ROT_EN);
        case (op)
            OP_DUP, OP_DROP:                                       need = 1;
            OP_OVER, OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: need = 2;
            OP_ROT:                                                need = 3;
            default:                                               need = 0;
        endcase
        grows = (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
        if (!legal || (m.size() < need) || (grows && (m.size() == DEPTH + 1))) begin
            m_err = 1'b1;
            return 1;
        end
        case (op)
            OP_PUSH: m.push_back(v);
            OP_DUP:  m.push_back(m_tos());
            OP_OVER: m.push_back(m_nos());
            OP_DROP: void'(m.pop_back());
            OP_SWAP: begin
                b = m.pop_back(); a = m.pop_back();
                m.push_back(b); m.push_back(a);
                return 2;
            end
            OP_ROT: begin
                c = m.pop_back(); b = m.pop_back(); a = m.pop_back();
                m.push_back(b); m.push_back(c); m.push_back(a);
                return 4;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                b = m.pop_back(); a = m.pop_back();
                case (op)
                    OP_ADD:  c = a + b;
                    OP_SUB:  c = a - b;
                    OP_AND:  c = a & b;
                    OP_OR:   c = a | b;
                    default: c = a ^ b;
                endcase
                m.push_back(c);
            end
            default: ;
        endcase
        return 1;
    endfunction

    // Called at a negedge; returns at a negedge with the command fully retired.
    task automatic do_op(input logic [3:0] op, input logic [31:0] v, input string tag);
        int exp_n;
        int n;
        exp_n     = model_step(op, v);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_val   = v;
        #1;
        check({tag, ".rdy"}, cmd_ready, 1);
        @(posedge clk); @(negedge clk);
        n = 1;
        while (busy && n < 10) begin
            cmd_valid = 1'b1;
            cmd_op    = 4'($urandom);
            cmd_val   = $urandom;
            @(posedge clk); @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        check({tag, ".cycles"}, n, exp_n);
        check({tag, ".tos"}, tos, m_tos());
        check({tag, ".depth"}, depth, m.size());
        check({tag, ".nos"}, ss.s, m_nos());
        check({tag, ".err"}, err, m_err);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst   = 1'b0;
        m.delete();
        m_err = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        cmd_val   = 32'h55;
        m_err     = 1'b0;
        @(negedge clk);
        check("rst.ss_op", ss.op, SS_NOP);
        @(posedge clk); @(negedge clk);
        check("rst.tos", tos, 0);
        check("rst.depth", depth, 0);
        check("rst.err", err, 0);
        check("rst.busy", busy, 0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("rst.rdy", cmd_ready, 1);
        @(negedge clk);

        do_op(OP_PUSH, 32'd1, "push1");
        do_op(OP_PUSH, 32'd2, "push2");
        do_op(OP_PUSH, 32'd3, "push3");
        check("push3.tos_is_3", tos, 3);
        do_op(OP_SWAP, 32'd0, "swap");
        check("swap.tos_is_2", tos, 2);
        check("swap.nos_is_3", ss.s, 3);
        do_op(OP_SUB, 32'd0, "sub");
        check("sub.tos_is_1", tos, 1);

        do_reset();
        do_op(OP_PUSH, 32'd1, "rpush1");
        do_op(OP_PUSH, 32'd2, "rpush2");
        do_op(OP_PUSH, 32'd3, "rpush3");
        do_op(OP_ROT, 32'd0, "rot");
        do_op(OP_DROP, 32'd0, "rot.pop1");
        do_op(OP_DROP, 32'd0, "rot.pop2");

        do_reset();
        do_op(OP_DROP, 32'd0, "under");
        check("under.err_set", err, 1);
        do_op(OP_PUSH, 32'd5, "under.next");
        do_op(4'd13, 32'd0, "illegal");

        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) do_op(OP_PUSH, 32'd100 + 32'(i), "fill");
        check("fill.depth17", depth, 17);
        do_op(OP_DUP, 32'd0, "over.dup");
        check("over.err_set", err, 1);

        do_reset();
        do_op(OP_PUSH, 32'hFFFF_FFFF, "wrap.a");
        do_op(OP_PUSH, 32'd1, "wrap.b");
        do_op(OP_ADD, 32'd0, "wrap.add");
        check("wrap.tos_zero", tos, 0);

        // en low in the middle of SWAP freezes S1 until en returns.
        do_reset();
        do_op(OP_PUSH, 32'd1, "p.push1");
        do_op(OP_PUSH, 32'd2, "p.push2");
        do_op(OP_PUSH, 32'd3, "p.push3");
        void'(model_step(OP_SWAP, 32'd0));
        cmd_valid = 1'b1;
        cmd_op    = OP_SWAP;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        en        = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("pause.busy", busy, 1);
        check("pause.tos", tos, 2);
        check("pause.depth", depth, 3);
        check("pause.rdy", cmd_ready, 0);
        en = 1'b1;
        @(posedge clk); @(negedge clk);
        check("pause.done", busy, 0);
        check("pause.tos_end", tos, m_tos());
        check("pause.nos_end", ss.s, m_nos());

        // Reset taken while a multi-cycle op sits in S1.
        do_reset();
        do_op(OP_PUSH, 32'd1, "k.push1");
        do_op(OP_PUSH, 32'd2, "k.push2");
        do_op(OP_PUSH, 32'd3, "k.push3");
        cmd_valid = 1'b1;
        cmd_op    = ROT_EN ? OP_ROT : OP_SWAP;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        check("kill.in_s1", busy, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("kill.idle", busy, 0);
        check("kill.tos", tos, 0);
        check("kill.depth", depth, 0);
        rst = 1'b0;
        m.delete();
        m_err = 1'b0;
        #1;
        check("kill.rdy", cmd_ready, 1);
        @(negedge clk);
        do_op(OP_PUSH, 32'd9, "kill.after");

        for (int k = 0; k < 400; k++) begin
            if (k % 60 == 0) do_reset();
            if ($urandom_range(0, 7) == 0) begin
                en        = 1'b0;
                cmd_valid = 1'b1;
                cmd_op    = OP_PUSH;
                cmd_val   = $urandom;
                #1;
                check("rnd.en_low_rdy", cmd_ready, 0);
                @(posedge clk); @(negedge clk);
                check("rnd.en_low_depth", depth, m.size());
                check("rnd.en_low_tos", tos, m_tos());
                en        = 1'b1;
                cmd_valid = 1'b0;
            end
            rsel = $urandom_range(0, 99);
            if (rsel < 35)      rop = OP_PUSH;
            else if (rsel < 40) rop = OP_DUP;
            else if (rsel < 45) rop = OP_OVER;
            else if (rsel < 60) rop = OP_DROP;
            else if (rsel < 70) rop = OP_SWAP;
            else if (rsel < 75) rop = OP_ROT;
            else if (rsel < 92) rop = 4'($urandom_range(7, 11));
            else                rop = 4'($urandom_range(0, 15));
            do_op(rop, $urandom, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dstack_seq.md
DSTACK_SEQ -- requirements
Module: dstack_seq

Interface
- REQ-001 SHALL have parameter DEPTH, default 16, meaning stack slave entries excluding the cached TOS.
- REQ-002 SHALL have parameter DSZ, default 32, meaning cell width in bits.
- REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
- REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
- REQ-005 SHALL have port en, input, 1 bit; when low, all state holds and the stack op is NOP.
- REQ-006 SHALL have port cmd_valid, input, 1 bit, command offered.
- REQ-007 SHALL have port cmd_ready, output, 1 bit, command accepted this cycle.
- REQ-008 SHALL have port cmd_op, input, 4 bits, sq_op_t opcode.
- REQ-009 SHALL have port cmd_val, input, DSZ bits, literal for PUSH.
- REQ-010 SHALL have port tos, output, DSZ bits, cached top of stack.
- REQ-011 SHALL have port depth, output, $clog2(DEPTH+1)+1 bits, total cells including TOS.
- REQ-012 SHALL have port busy, output, 1 bit, FSM not IDLE.
- REQ-013 SHALL have port err, output, 1 bit, sticky underflow, overflow or illegal-op flag.
- REQ-014 SHALL have port ss_if, interface ss_io.master, driving op/vi and sampling s.

Function
- REQ-015 SHALL hold cmd_ready high only in IDLE with en high; a transfer occurs when cmd_valid && cmd_ready.
- REQ-016 SHALL drive ss_if per cycle: push writes vi and pop removes an entry, both committed at the next posedge; s is the combinational top stored entry (NOS).
- REQ-017 SHALL use FSM states IDLE, S1, S2, S3: single-cycle ops stay in IDLE; SWAP goes IDLE->S1->IDLE; ROT goes IDLE->S1->S2->S3->IDLE.
- REQ-018 SHALL execute NOP with no effect.
- REQ-019 SHALL execute PUSH n as: push tos, tos<=n, depth+1.
- REQ-020 SHALL execute DUP as: push tos, depth+1.
- REQ-021 SHALL execute OVER as: push tos, tos<=s sampled pre-push, depth+1.
- REQ-022 SHALL execute DROP as: tos<=s, pop, depth-1.
- REQ-023 SHALL execute ADD/SUB/AND/OR/XOR as: tos<=s op tos, pop, depth-1.
- REQ-024 SHALL compute SUB as NOS-TOS, modulo 2^DSZ, with no carry out.
- REQ-025 SHALL execute SWAP as: cycle 0 pop, tmp<=tos, tos<=s; S1 push tmp; depth unchanged.
- REQ-026 SHALL execute ROT (a b c -> b c a; c=tos) as: cycle 0 pop, tmp<=s(b); S1 pop, tos<=s(a), tmp2<=old tos(c); S2 push tmp(b); S3 push tmp2(c).
- REQ-027 SHALL require minimum depth of 1 for DUP/DROP, 2 for OVER/SWAP/ALU ops, and 3 for ROT.
- REQ-028 SHALL treat an op below its minimum depth as underflow: set err, no stack or tos change, stay in IDLE.
- REQ-029 SHALL treat PUSH/DUP/OVER at depth == DEPTH+1 as overflow: set err, no change.
- REQ-030 SHALL treat an undefined opcode as illegal: set err, no change.
- REQ-031 SHALL clear err only by reset.
- REQ-032 SHALL pause a multi-cycle op in its current state while en is low, with op NOP, and resume when en returns high.
- REQ-033 SHALL latch cmd_val at acceptance; cmd inputs are ignored while busy.

Reset
- REQ-034 SHALL set, on rst at a posedge: state IDLE, tos=0, depth=0, err=0, tmp regs=0, ss_if.op=NOP; reset has priority over en and over any in-flight SWAP/ROT.
- REQ-035 SHALL reach the stack slave with the same rst, so both ends restart empty together.

Configuration
- REQ-036 SHALL compile in ROT, states S2/S3 and tmp2 when DSTACK_SEQ_ROT_EN is defined.
- REQ-037 SHALL, without DSTACK_SEQ_ROT_EN, omit S2/S3 and tmp2 and treat the ROT opcode as illegal (err=1, no change).

Structure
- REQ-038 SHALL place sq_op_t (NOP, PUSH, DUP, OVER, DROP, SWAP, ROT, ADD, SUB, AND, OR, XOR) and the ss_io op enum in shared package forth_pkg.
- REQ-039 SHALL implement the ALU as combinational sub-module dstack_alu(op, a, b, y).

Verification
- REQ-040 SHALL cover: PUSH 1, 2, 3 -> tos=3, depth=3, s=2, err=0.
- REQ-041 SHALL cover: from 1 2 3, SWAP -> 2 cycles, busy=1 for 1 cycle, tos=2, s=3; then SUB -> tos=1 (3-2), depth=2.
- REQ-042 SHALL cover, with DSTACK_SEQ_ROT_EN: from 1 2 3, ROT -> 4 cycles, tos=1, then pops yield 3, 2.
- REQ-043 SHALL cover: DROP at depth=0 -> err=1, depth=0, tos unchanged; further ops still execute.
- REQ-044 SHALL cover: PUSH to depth=17, then DUP -> err=1, depth stays 17; PUSH 'hFFFFFFFF then ADD 1 -> tos=0.
- REQ-045 SHALL cover: rst asserted during ROT S1 -> next cycle IDLE, tos=0, depth=0, cmd_ready=1.
